// File: rtl/shift_left_two_pkg.sv
// Shared pipeline definitions for the shift_left_two block.
//   DEFAULT_WIDTH : default datapath width
//   DEFAULT_SHAMT : default fixed left-shift amount
//   occ_t         : 2-bit occupancy count for the two-entry skid buffer
package shift_left_two_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_SHAMT = 2;

    typedef logic [1:0] occ_t;

    localparam occ_t OCC_EMPTY = 2'd0;
    localparam occ_t OCC_ONE   = 2'd1;
    localparam occ_t OCC_FULL  = 2'd2;

endpackage

// File: rtl/shift_left_two_if.sv
// Bus bundle for shift_left_two.
//   In32      : operand (drives the combinational shift and the channel)
//   Out32     : combinational In32 << SHAMT
//   in_valid / in_ready   : input handshake of the registered channel
//   out_valid / out_ready : output handshake of the registered channel
//   out_data / out_ovf / out_sgn : registered result and flags
// Modports: master = the side producing In32 and consuming results,
//           slave  = the shift_left_two block itself.
interface shift_left_two_if
    import shift_left_two_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic [WIDTH-1:0] In32;
    logic [WIDTH-1:0] Out32;
    logic             in_valid;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_ovf;
    logic             out_sgn;

    modport master (
        output In32,
        output in_valid,
        output out_ready,
        input  Out32,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_ovf,
        input  out_sgn
    );

    modport slave (
        input  In32,
        input  in_valid,
        input  out_ready,
        output Out32,
        output in_ready,
        output out_valid,
        output out_data,
        output out_ovf,
        output out_sgn
    );
endinterface

// File: rtl/shift_left_two_skid_buffer2.sv
// skid_buffer2: two-entry valid/ready buffer with one cycle of latency.
//   clk, rst            : clock and synchronous active-high reset
//   in_valid/in_ready   : upstream handshake, in_data payload
//   out_valid/out_ready : downstream handshake, out_data payload
// Entry 0 (head_reg) always drives the output; entry 1 (tail_reg) only
// fills when the head is stalled. in_ready is decoded from the occupancy
// register alone, so there is no combinational path from out_ready.
module skid_buffer2
    import shift_left_two_pkg::*;
#(
    parameter int DW = DEFAULT_WIDTH + 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    occ_t          occ_reg;
    occ_t          occ_next;
    logic [DW-1:0] head_reg;
    logic [DW-1:0] head_next;
    logic [DW-1:0] tail_reg;
    logic [DW-1:0] tail_next;
    logic          push;
    logic          pop;

    assign in_ready  = (occ_reg != OCC_FULL);
    assign out_valid = (occ_reg != OCC_EMPTY);
    assign out_data  = head_reg;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_comb begin
        occ_next  = occ_reg;
        head_next = head_reg;
        tail_next = tail_reg;
        case (occ_reg)
            OCC_EMPTY: begin
                if (push) begin
                    head_next = in_data;
                    occ_next  = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (push && pop) begin
                    // Head leaves and the newcomer takes its place.
                    head_next = in_data;
                end else if (push) begin
                    tail_next = in_data;
                    occ_next  = OCC_FULL;
                end else if (pop) begin
                    occ_next  = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                // in_ready is low here, so only a pop can happen.
                if (pop) begin
                    head_next = tail_reg;
                    occ_next  = OCC_ONE;
                end
            end
            default: begin
                occ_next = OCC_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_reg  <= OCC_EMPTY;
            head_reg <= '0;
            tail_reg <= '0;
        end else begin
            occ_reg  <= occ_next;
            head_reg <= head_next;
            tail_reg <= tail_next;
        end
    end

endmodule

// File: rtl/shift_left_two.sv
// shift_left_two: fixed left shift by SHAMT with two outputs.
//   clk, rst : clock and synchronous active-high reset (channel only)
//   bus      : shift_left_two_if.slave
//     Out32  -- purely combinational In32 << SHAMT, unaffected by clk/rst
//     in_*/out_* -- registered channel carrying the shifted value plus
//                   out_ovf (nonzero bits shifted out) and out_sgn
//                   (result MSB differs from operand MSB) through a
//                   two-entry skid buffer.
module shift_left_two
    import shift_left_two_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SHAMT = DEFAULT_SHAMT
) (
    input  logic            clk,
    input  logic            rst,
    shift_left_two_if.slave bus
);

    logic [WIDTH-1:0] shifted;
    logic             ovf;
    logic             sgn;
    logic [WIDTH+1:0] payload_in;
    logic [WIDTH+1:0] payload_out;

    // Low SHAMT bits are zero fill, the rest come from SHAMT places below.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
        if (gi < SHAMT) begin : g_zero
            assign shifted[gi] = 1'b0;
        end else begin : g_move
            assign shifted[gi] = bus.In32[gi-SHAMT];
        end
    end

    assign bus.Out32 = shifted;

    // The bits that fall off the top; any one set means overflow.
    assign ovf = |bus.In32[WIDTH-1 -: SHAMT];
    // The new MSB is the operand bit SHAMT below the old MSB.
    assign sgn = bus.In32[WIDTH-1] ^ bus.In32[WIDTH-1-SHAMT];

    assign payload_in = {ovf, sgn, shifted};

    skid_buffer2 #(
        .DW(WIDTH + 2)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (payload_in),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (payload_out)
    );

    assign bus.out_ovf  = payload_out[WIDTH+1];
    assign bus.out_sgn  = payload_out[WIDTH];
    assign bus.out_data = payload_out[WIDTH-1:0];

endmodule

// File: tb/tb_shift_left_two.sv
// Directed testbench for shift_left_two (WIDTH=32, SHAMT=2).
// Inputs change on the falling edge; outputs are sampled 1 ns after the
// rising edge. Every comparison goes through check().
module tb_shift_left_two;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    shift_left_two_if #(.WIDTH(32)) bus_if ();

    shift_left_two #(
        .WIDTH(32),
        .SHAMT(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%08h", tag, got);
        end
    endtask

    // Drive inputs at the falling edge, wait for the rising edge, settle 1 ns.
    task automatic step(input logic v, input logic [31:0] d, input logic rdy);
        @(negedge clk);
        bus_if.in_valid  = v;
        bus_if.In32      = d;
        bus_if.out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus_if.In32      = 32'h0;
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, bus_if.in_ready},  32'd1);
        check("rst_out_data",  bus_if.out_data,           32'h0);
        check("rst_out_ovf",   {31'd0, bus_if.out_ovf},   32'd0);
        check("rst_out_sgn",   {31'd0, bus_if.out_sgn},   32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Combinational path: no clock edge between change and sample.
        bus_if.In32 = 32'h3000_0000;
        #1;
        check("comb_30", bus_if.Out32, 32'hC000_0000);
        bus_if.In32 = 32'h1000_0000;
        #0;
        check("comb_10", bus_if.Out32, 32'h4000_0000);

        // Registered: 0x30000000 -> 0xC0000000, ovf 0, sgn 1.
        step(1'b1, 32'h3000_0000, 1'b1);
        check("ch30_valid", {31'd0, bus_if.out_valid}, 32'd1);
        check("ch30_data",  bus_if.out_data,           32'hC000_0000);
        check("ch30_ovf",   {31'd0, bus_if.out_ovf},   32'd0);
        check("ch30_sgn",   {31'd0, bus_if.out_sgn},   32'd1);

        // Back-to-back at occupancy 1: 0xC0000001 -> 0x4, ovf 1, sgn 1.
        step(1'b1, 32'hC000_0001, 1'b1);
        check("chC1_data",  bus_if.out_data,           32'h0000_0004);
        check("chC1_ovf",   {31'd0, bus_if.out_ovf},   32'd1);
        check("chC1_sgn",   {31'd0, bus_if.out_sgn},   32'd1);
        check("chC1_ready", {31'd0, bus_if.in_ready},  32'd1);

        step(1'b0, 32'h0, 1'b1);
        check("drain_valid", {31'd0, bus_if.out_valid}, 32'd0);

        // Back-pressure: 1,2,3 with out_ready low.
        step(1'b1, 32'h1, 1'b0);
        check("bp1_ready", {31'd0, bus_if.in_ready}, 32'd1);
        check("bp1_data",  bus_if.out_data,          32'h4);
        step(1'b1, 32'h2, 1'b0);
        check("bp2_ready", {31'd0, bus_if.in_ready}, 32'd0);
        step(1'b1, 32'h3, 1'b0);
        check("bp3_ready", {31'd0, bus_if.in_ready}, 32'd0);
        check("bp3_hold",  bus_if.out_data,          32'h4);
        check("bp3_ovf",   {31'd0, bus_if.out_ovf},  32'd0);
        // Release: 0x4 leaves, 0x3 still blocked this edge.
        step(1'b1, 32'h3, 1'b1);
        check("rel1_data",  bus_if.out_data,          32'h8);
        check("rel1_ready", {31'd0, bus_if.in_ready}, 32'd1);
        // 0x8 leaves while 0x3 enters.
        step(1'b1, 32'h3, 1'b1);
        check("rel2_data",  bus_if.out_data,           32'hC);
        check("rel2_valid", {31'd0, bus_if.out_valid}, 32'd1);
        step(1'b0, 32'h0, 1'b1);
        check("rel3_valid", {31'd0, bus_if.out_valid}, 32'd0);

        // Reset with two entries held; handshake in the reset cycle ignored.
        step(1'b1, 32'h0000_0011, 1'b0);
        step(1'b1, 32'h0000_0022, 1'b0);
        check("full_ready", {31'd0, bus_if.in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        bus_if.In32      = 32'h0000_0033;
        bus_if.in_valid  = 1'b1;
        bus_if.out_ready = 1'b1;
        #1;
        check("rst_comb", bus_if.Out32, 32'h0000_00CC);
        @(posedge clk);
        #1;
        check("mrst_valid", {31'd0, bus_if.out_valid}, 32'd0);
        check("mrst_ready", {31'd0, bus_if.in_ready},  32'd1);
        check("mrst_data",  bus_if.out_data,           32'h0);
        bus_if.In32 = 32'h8000_0001;
        #1;
        check("mrst_comb", bus_if.Out32, 32'h0000_0004);
        @(negedge clk);
        rst = 1'b0;
        bus_if.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("post_valid", {31'd0, bus_if.out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/shift_left_two.md
SHIFT_LEFT_TWO -- requirements
Module: shift_left_two

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of In32/Out32/out_data.
REQ-002 SHALL have parameter SHAMT, default 2, fixed left-shift amount (1..WIDTH-1).
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for the registered channel.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 In32  input  WIDTH  operand, e.g. sign-extended branch offset.
REQ-007 Out32  output  WIDTH  combinational In32 shifted left by SHAMT.
REQ-008 in_valid  input  1  In32 valid for the registered channel.
REQ-009 in_ready  output  1  channel can accept In32 this cycle.
REQ-010 out_valid  output  1  out_data/out_ovf/out_sgn valid.
REQ-011 out_ready  input  1  downstream accepts the registered result.
REQ-012 out_data  output  WIDTH  registered shifted value.
REQ-013 out_ovf  output  1  registered flag: any nonzero bit shifted out.
REQ-014 out_sgn  output  1  registered flag: result MSB differs from operand MSB.

Function
REQ-015 Out32 SHALL equal {In32[WIDTH-1-SHAMT:0], SHAMT zero bits}, purely combinational, zero latency, independent of clk, rst and the handshake.
REQ-016 Out32 SHALL update in the same delta as In32; no latch, no storage.
REQ-017 A transfer in SHALL occur on a rising clk edge when in_valid and in_ready are both 1.
REQ-018 A transfer out SHALL occur on a rising clk edge when out_valid and out_ready are both 1.
REQ-019 The registered channel SHALL be a 2-entry skid buffer: one-cycle latency from accepted input to out_valid, sustaining one transfer per cycle while out_ready is held 1.
REQ-020 in_ready SHALL be 1 whenever fewer than 2 entries are held, and SHALL depend only on registered state, with no combinational path from out_ready.
REQ-021 With 2 entries held and out_ready 0, in_ready SHALL be 0 and the stored values SHALL stay stable.
REQ-022 A simultaneous in- and out-transfer at occupancy 1 SHALL leave occupancy 1 and present the newer entry next cycle.
REQ-023 Entries SHALL leave in acceptance order.
REQ-024 out_ovf SHALL be 1 exactly when In32[WIDTH-1:WIDTH-SHAMT] of that entry was nonzero.
REQ-025 out_sgn SHALL be In32[WIDTH-1] XOR In32[WIDTH-1-SHAMT] of that entry.
REQ-026 out_data, out_ovf and out_sgn SHALL hold their value while out_valid is 1 and out_ready is 0.

Reset
REQ-027 On a rising clk edge with rst=1, occupancy SHALL become 0, out_valid 0, out_data all zeros, out_ovf 0 and out_sgn 0.
REQ-028 in_ready SHALL read 1 in the cycle after reset.
REQ-029 A reset mid-operation SHALL discard all held entries; handshakes in that cycle SHALL be ignored.
REQ-030 Out32 SHALL NOT be affected by rst.

Structure
REQ-031 WIDTH and SHAMT defaults, and a 2-bit occupancy type, SHALL live in the shared pipeline package.
REQ-032 The skid buffer SHALL be one sub-module, skid_buffer2, with a payload of WIDTH+2 bits; shift and flag logic SHALL stay in the top.

Verification
REQ-033 In32=0x30000000 -> Out32=0xC0000000 immediately; registered: out_ovf=0, out_sgn=1.
REQ-034 In32 changes to 0x10000000 after 1 ns -> Out32=0x40000000 within the same time step; no clock edge is needed.
REQ-035 In32=0xC0000001 sent through the channel -> out_data=0x00000004, out_ovf=1, out_sgn=1, one cycle after acceptance.
REQ-036 Back-pressure: send 0x1, 0x2, 0x3 with out_ready=0 -> in_ready drops after two accepts; release -> outputs 0x4, 0x8, 0xC in order, nothing lost or duplicated.
REQ-037 Assert rst with 2 entries held -> next cycle out_valid=0, in_ready=1, out_data=0; Out32 still tracks In32 throughout.
